// File: rtl/fp_pkg.sv
// Shared definitions for the front-panel event queue: the evt_data word layout
// and the format of entries stored in the event FIFO.
package fp_pkg;

  localparam int FP_EVT_CLICK   = 0;
  localparam int FP_EVT_CW      = 1;
  localparam int FP_EVT_SW      = 2;
  localparam int FP_EVT_VALID   = 3;
  localparam int FP_EVT_OVF     = 4;
  localparam int FP_EVT_SEQ_LSB = 5;

  localparam int FP_SEQ_W   = 3;
  // Stored entry is {seq, sw, cw, click}; valid and ovf are added at the read port.
  localparam int FP_ENTRY_W = FP_SEQ_W + 3;

  typedef struct packed {
    logic [FP_SEQ_W-1:0] seq;
    logic                ovf;
    logic                valid;
    logic                sw;
    logic                cw;
    logic                click;
  } fp_event_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Generic first-word-fall-through FIFO. Push is accepted when full only if a
// pop frees a slot in the same cycle; pop on an empty FIFO is ignored.
module fp_sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/fp_event_queue.sv
// Front-panel encoder event queue: sequence-tagged event FIFO with sticky
// overflow, a saturating detent accumulator and a registered interrupt.
module fp_event_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   evt_stb,
  input  logic                   evt_click,
  input  logic                   evt_clkwise,
  input  logic                   evt_switch,
  input  logic                   irq_enable,
  input  logic                   cpu_rd_stb,
  input  logic                   cpu_cnt_rd_stb,
  output logic [7:0]             evt_data,
  output logic [$clog2(DEPTH):0] evt_level,
  output logic [CNT_W-1:0]       detent_count,
  output logic                   irq
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FP_ENTRY_W-1:0] fifo_dout;
  logic [LW-1:0]         level_next;
  logic [FP_SEQ_W-1:0]   seq;
  logic                  overflow;
  logic                  ovf_next;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  drop;
  logic                  click_evt;
  fp_event_t             head;

  assign pop_ok    = cpu_rd_stb && !fifo_empty;
  assign push_ok   = evt_stb && (!fifo_full || pop_ok);
  assign drop      = evt_stb && fifo_full && !cpu_rd_stb;
  assign click_evt = evt_stb && evt_click;

  fp_sync_fifo #(
    .WIDTH (FP_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   ({seq, evt_switch, evt_clkwise, evt_click}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (evt_level)
  );

  // Look-ahead level and overflow so irq lines up with the state it reports.
  always_comb begin
    level_next = evt_level;
    ovf_next   = overflow;
    if (push_ok && !pop_ok)      level_next = evt_level + 1'b1;
    else if (!push_ok && pop_ok) level_next = evt_level - 1'b1;
    if (drop)            ovf_next = 1'b1;
    else if (cpu_rd_stb) ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq      <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (push_ok) seq <= seq + 1'b1;
      overflow <= ovf_next;
      irq      <= irq_enable && ((level_next != '0) || ovf_next);
    end
  end

  // A click coinciding with read-and-clear restarts the count at +/-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      detent_count <= '0;
    end else if (cpu_cnt_rd_stb) begin
      if (click_evt) detent_count <= evt_clkwise ? CNT_W'(1) : '1;
      else           detent_count <= '0;
    end else if (click_evt) begin
      if (evt_clkwise && detent_count != CNT_MAX)       detent_count <= detent_count + 1'b1;
      else if (!evt_clkwise && detent_count != CNT_MIN) detent_count <= detent_count - 1'b1;
    end
  end

  always_comb begin
    head     = '0;
    head.ovf = overflow;
    if (!fifo_empty) begin
      head.seq   = fifo_dout[FP_ENTRY_W-1:3];
      head.valid = 1'b1;
      head.sw    = fifo_dout[2];
      head.cw    = fifo_dout[1];
      head.click = fifo_dout[0];
    end
    evt_data = head;
  end

endmodule

// File: tb/tb_fp_event_queue.sv
// Self-checking bench for fp_event_queue: a reference model with an event
// scoreboard that is compared whenever the CPU pops the head word.
module tb_fp_event_queue;
  import fp_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             evt_stb, evt_click, evt_clkwise, evt_switch;
  logic             irq_enable, cpu_rd_stb, cpu_cnt_rd_stb;
  logic [7:0]       evt_data;
  logic [LW-1:0]    evt_level;
  logic [CNT_W-1:0] detent_count;
  logic             irq;

  int errors = 0;
  int checks = 0;

  logic [5:0]       sb_q[$];
  logic [2:0]       m_seq;
  logic             m_ovf;
  logic [CNT_W-1:0] m_cnt;
  logic             m_irq;

  fp_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .evt_stb        (evt_stb),
    .evt_click      (evt_click),
    .evt_clkwise    (evt_clkwise),
    .evt_switch     (evt_switch),
    .irq_enable     (irq_enable),
    .cpu_rd_stb     (cpu_rd_stb),
    .cpu_cnt_rd_stb (cpu_cnt_rd_stb),
    .evt_data       (evt_data),
    .evt_level      (evt_level),
    .detent_count   (detent_count),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] expData();
    if (sb_q.size() == 0) return {3'b000, m_ovf, 4'b0000};
    return {sb_q[0][5:3], m_ovf, 1'b1, sb_q[0][2:0]};
  endfunction

  task automatic checkAll();
    checkOutput("level", 32'(evt_level), 32'(sb_q.size()));
    checkOutput("data",  32'(evt_data),  32'(expData()));
    checkOutput("count", 32'(detent_count), 32'(m_cnt));
    checkOutput("irq",   32'(irq), 32'(m_irq));
  endtask

  // One clock of stimulus; the model advances from its pre-edge state.
  task automatic applyStimulus(input logic stb, input logic click, input logic cw,
                               input logic sw, input logic rd, input logic cntrd);
    logic [7:0] head;
    logic [5:0] e;
    logic full, empty, pop, push, drop, clk_evt;
    evt_stb = stb; evt_click = click; evt_clkwise = cw; evt_switch = sw;
    cpu_rd_stb = rd; cpu_cnt_rd_stb = cntrd;
    head = evt_data;
    @(posedge clk);
    full    = (sb_q.size() == DEPTH);
    empty   = (sb_q.size() == 0);
    pop     = rd && !empty;
    push    = stb && (!full || pop);
    drop    = stb && full && !rd;
    clk_evt = stb && click;
    if (pop) begin
      e = sb_q.pop_front();
      checkOutput("pop_head", 32'(head), 32'({e[5:3], m_ovf, 1'b1, e[2:0]}));
    end
    if (push) begin
      sb_q.push_back({m_seq, sw, cw, click});
      m_seq = m_seq + 3'd1;
    end
    if (drop)    m_ovf = 1'b1;
    else if (rd) m_ovf = 1'b0;
    if (cntrd) begin
      m_cnt = clk_evt ? (cw ? 8'd1 : 8'hFF) : 8'd0;
    end else if (clk_evt) begin
      if (cw && m_cnt != 8'h7F)       m_cnt = m_cnt + 8'd1;
      else if (!cw && m_cnt != 8'h80) m_cnt = m_cnt - 8'd1;
    end
    m_irq = irq_enable && (sb_q.size() != 0 || m_ovf);
    #1;
    evt_stb = 0; cpu_rd_stb = 0; cpu_cnt_rd_stb = 0;
    checkAll();
  endtask

  task automatic doReset();
    reset = 1'b1;
    evt_stb = 0; evt_click = 0; evt_clkwise = 0; evt_switch = 0;
    cpu_rd_stb = 0; cpu_cnt_rd_stb = 0;
    @(posedge clk);
    sb_q.delete();
    m_seq = 0; m_ovf = 0; m_cnt = 0; m_irq = 0;
    #1;
    reset = 1'b0;
    checkAll();
  endtask

  initial begin
    irq_enable = 1'b1;
    #2;
    doReset();
    checkOutput("rst_data", 32'(evt_data), 32'h00);
    checkOutput("rst_level", 32'(evt_level), 32'd0);

    // Three clockwise detents, irq must rise right after the first.
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("irq_first", 32'(irq), 32'd1);
    applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("tp1_level", 32'(evt_level), 32'd3);
    checkOutput("tp1_count", 32'(detent_count), 32'd3);
    checkOutput("tp1_data", 32'(evt_data), 32'h0B);

    for (int i = 0; i < 3; i++) begin
      checkOutput("tp2_seq", 32'(evt_data[7:FP_EVT_SEQ_LSB]), 32'(i));
      applyStimulus(0, 0, 0, 0, 1, 0);
    end
    checkOutput("tp2_data", 32'(evt_data), 32'h00);
    checkOutput("tp2_irq", 32'(irq), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Overfill: eight stored, two dropped.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, i[0], i[1], i[2], 0, 0);
    checkOutput("tp3_level", 32'(evt_level), 32'd8);
    checkOutput("tp3_ovf", 32'(evt_data[FP_EVT_OVF]), 32'd1);
    checkOutput("tp3_last_seq", 32'(sb_q[$][5:3]), 32'd7);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("tp3_ovf_clr", 32'(evt_data[FP_EVT_OVF]), 32'd0);
    checkOutput("tp3_level7", 32'(evt_level), 32'd7);

    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 0);
    checkOutput("tp4_level", 32'(evt_level), 32'd8);
    checkOutput("tp4_ovf", 32'(evt_data[FP_EVT_OVF]), 32'd0);

    // Saturation in both directions, then clear with a coincident click.
    doReset();
    for (int i = 0; i < 130; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("tp5_neg_sat", 32'(detent_count), 32'h80);
    applyStimulus(1, 1, 1, 0, 0, 1);
    checkOutput("tp5_clr_click", 32'(detent_count), 32'h01);
    for (int i = 0; i < 130; i++) applyStimulus(1, 1, 1, 0, 1, 0);
    checkOutput("tp5_pos_sat", 32'(detent_count), 32'h7F);

    // Reset mid-operation with full queue and overflow set.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    doReset();
    checkOutput("tp6_level", 32'(evt_level), 32'd0);
    checkOutput("tp6_ovf", 32'(evt_data[FP_EVT_OVF]), 32'd0);
    checkOutput("tp6_irq", 32'(irq), 32'd0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("tp6_seq0", 32'(evt_data), 32'h0B);

    // Random traffic with irq_enable toggling.
    for (int i = 0; i < 400; i++) begin
      irq_enable = ($urandom_range(0, 7) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    irq_enable = 1'b0;
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("irq_masked", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
